// File: rtl/bt_uart_rx_if.sv
// bt_uart_rx_if: serial line plus receive-side outputs of the Bluetooth UART receiver
// Signals: rx (line, idles high), data (held byte), data_valid / frame_err (1-cycle strobes),
// busy (frame in progress), timeout (link-loss flag).
// Modports: master = line driver / consumer of received bytes, slave = the receiver.
interface bt_uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       timeout;
    modport master (output rx, input data, data_valid, frame_err, busy, timeout);
    modport slave (input rx, output data, data_valid, frame_err, busy, timeout);
endinterface

// File: rtl/bt_uart_rx.sv
// bt_uart_rx: 8N1 UART receiver with held output byte, strobes and optional link-loss failsafe
// Ports: clk (only clock), rst_n (synchronous, active-low),
//        bus (bt_uart_rx_if.slave: rx in; data, data_valid, frame_err, busy, timeout out).
// Optional feature macro: BT_RX_TIMEOUT_EN (link-loss failsafe forcing data to 0x00).
module bt_uart_rx #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TIMEOUT_MS = 500
) (
    input logic         clk,
    input logic         rst_n,
    bt_uart_rx_if.slave bus
);
    localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned TW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
    if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DIV == 0 || TIMEOUT_MS == 0) begin : g_bad_cfg
        $error("bt_uart_rx: invalid parameter set");
    end
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t        state_q;
    logic          rx_meta_q, rx_s_q;
    logic [TW-1:0] tick_cnt_q;
    logic          tick_q;
    logic [SW-1:0] samp_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, data_q;
    logic          data_valid_q, frame_err_q;
    logic          tick_wrap_d, load_d;
    assign tick_wrap_d = tick_cnt_q == TICK_LAST;
    assign load_d = state_q == STOP && tick_q && samp_q == SAMP_LAST && rx_s_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end
`ifdef BT_RX_TIMEOUT_EN
    localparam logic [31:0] LIMIT_LAST = 32'(TIMEOUT_MS * (CLK_HZ / 1000) - 1);
    logic [31:0] to_cnt_q;
    logic        timeout_q;
`endif
    // tick_q is a registered copy of the divider wrap, so each bit event lands one
    // cycle after the divider boundary; the divider restarts on the start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
            samp_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef BT_RX_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            tick_cnt_q   <= tick_wrap_d ? '0 : tick_cnt_q + 1'b1;
            tick_q       <= tick_wrap_d;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef BT_RX_TIMEOUT_EN
            // Expiry is written first so a same-cycle byte load below overrides it.
            to_cnt_q <= to_cnt_q == LIMIT_LAST ? to_cnt_q : to_cnt_q + 1'b1;
            if (to_cnt_q == LIMIT_LAST) begin
                data_q    <= '0;
                timeout_q <= 1'b1;
            end
            if (load_d) begin
                to_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    state_q    <= START;
                    tick_cnt_q <= '0;
                    tick_q     <= 1'b0;
                    samp_q     <= '0;
                end
                START: if (tick_q) begin
                    samp_q <= samp_q + 1'b1;
                    if (samp_q == SAMP_MID) begin
                        state_q <= rx_s_q ? IDLE : DATA;
                        samp_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                DATA: if (tick_q) begin
                    samp_q <= samp_q + 1'b1;
                    if (samp_q == SAMP_LAST) begin
                        samp_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: if (tick_q) begin
                    samp_q <= samp_q + 1'b1;
                    if (samp_q == SAMP_LAST) begin
                        samp_q       <= '0;
                        state_q      <= rx_s_q ? IDLE : BREAK;
                        data_valid_q <= rx_s_q;
                        frame_err_q  <= !rx_s_q;
                        if (load_d) data_q <= shift_q;
                    end
                end
                BREAK: if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = state_q == START || state_q == DATA || state_q == STOP;
`ifdef BT_RX_TIMEOUT_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_bt_uart_rx.sv
// tb_bt_uart_rx: table-driven, scoreboarded bench for the bt_uart_rx 8N1 receiver
module tb_bt_uart_rx;
    localparam int unsigned CLK_HZ = 320_000;
    localparam int unsigned BAUD   = 10_000;
    localparam int unsigned OS     = 8;
    localparam int unsigned TMS    = 10;
    localparam int unsigned DIV    = CLK_HZ / (BAUD * OS);
    localparam int unsigned BIT    = OS * DIV;
    localparam int unsigned LAT    = 3 + (OS / 2 + 9 * OS) * DIV + 1;
    localparam int unsigned LIMIT  = TMS * (CLK_HZ / 1000);
    typedef struct {logic err; logic [7:0] d;} exp_t;
    typedef struct {logic [7:0] d; logic stop; logic [7:0] held;} vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_q = 1'b0;
    logic to_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int unsigned cyc = 0;
    int unsigned dv_cyc = 0;
    int unsigned to_cyc = 0;
    int unsigned start_cyc = 0;
    int dv_count = 0;
    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    vec_t vecs[6];
    bt_uart_rx_if bus ();
    bt_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .TIMEOUT_MS(TMS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.data_valid || bus.frame_err) begin
            if (bus.data_valid) begin
                dv_cyc = cyc;
                dv_count++;
                check("busy_at_strobe", 32'(bus.busy), 0);
            end
            check("strobe_exclusive", 32'(bus.data_valid & bus.frame_err), 0);
            if (exp_q.size() == 0) check("unexpected_strobe", 32'({bus.data_valid, bus.frame_err}), 0);
            else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(bus.frame_err), 32'(e.err));
                if (!e.err) check("strobe_data", 32'(bus.data), 32'(e.d));
            end
        end
        if (rst_q && !bus.data_valid && !bus.timeout) check("data_stable", 32'(bus.data), 32'(prev_data));
        if (bus.timeout && !to_prev) to_cyc = cyc;
        to_prev = bus.timeout;
        prev_data = bus.data;
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input logic [7:0] d, input logic stop);
        exp_t e;
        e.err = !stop;
        e.d = d;
        exp_q.push_back(e);
        start_cyc = cyc;
        bus.rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            tick(BIT);
        end
        bus.rx = stop;
        tick(BIT);
    endtask
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("strobe_pending", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask
    initial begin : watchdog
        #(200_000 * 10);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
    initial begin : stim
        int c0;
        bus.rx = 1'b1;
        vecs = '{'{8'h35, 1'b1, 8'h35}, '{8'h00, 1'b1, 8'h00}, '{8'hFF, 1'b1, 8'hFF},
                 '{8'hA5, 1'b0, 8'hFF}, '{8'h5A, 1'b1, 8'h5A}, '{8'h80, 1'b0, 8'h5A}};
        tick(4);
        check("rst_data", 32'(bus.data), 0);
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        rst_n = 1'b1;
        tick(5);
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, vecs[i].stop);
            if (vecs[i].stop) check("latency", dv_cyc - start_cyc, LAT);
            bus.rx = 1'b1;
            tick(BIT);
            drain(BIT);
            check("vec_data", 32'(bus.data), 32'(vecs[i].held));
            check("vec_busy", 32'(bus.busy), 0);
        end
        // glitch shorter than half a bit: START is entered, then rejected
        bus.rx = 1'b0;
        tick(4);
        check("glitch_busy_rise", 32'(bus.busy), 1);
        tick(5);
        bus.rx = 1'b1;
        tick(BIT);
        check("glitch_busy_fall", 32'(bus.busy), 0);
        check("glitch_data", 32'(bus.data), 8'h5A);
        drain(1);
        // framing error followed by a held-low break
        send(8'h35, 1'b1);
        bus.rx = 1'b1;
        tick(BIT);
        send(8'hA5, 1'b0);
        tick(BIT);
        check("break_busy", 32'(bus.busy), 0);
        tick(BIT);
        check("break_busy_end", 32'(bus.busy), 0);
        check("break_data", 32'(bus.data), 8'h35);
        drain(1);
        bus.rx = 1'b1;
        tick(BIT);
        send(8'h0F, 1'b1);
        bus.rx = 1'b1;
        tick(BIT);
        drain(BIT);
        check("after_break_data", 32'(bus.data), 8'h0F);
        // reset during data bit 4 of 0xC3
        bus.rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            bus.rx = (i < 2);
            tick(BIT);
        end
        bus.rx = 1'b0;
        tick(BIT / 2);
        check("pre_reset_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        bus.rx = 1'b1;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_data", 32'(bus.data), 0);
        check("mid_rst_strobes", 32'({bus.data_valid, bus.frame_err}), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_timeout", 32'(bus.timeout), 0);
        tick(2 * BIT);
        drain(1);
        send(8'h7E, 1'b1);
        bus.rx = 1'b1;
        tick(BIT);
        drain(BIT);
        check("after_rst_data", 32'(bus.data), 8'h7E);
        // back-to-back frames with no idle gap
        c0 = dv_count;
        send(8'h01, 1'b1);
        send(8'hFF, 1'b1);
        bus.rx = 1'b1;
        tick(BIT);
        drain(BIT);
        check("b2b_count", 32'(dv_count - c0), 2);
        check("b2b_data", 32'(bus.data), 8'hFF);
        // link-loss window after a good byte
        send(8'h42, 1'b1);
        bus.rx = 1'b1;
        drain(BIT);
`ifdef BT_RX_TIMEOUT_EN
        c0 = 0;
        while (!bus.timeout && c0 < int'(LIMIT + BIT)) begin
            tick(1);
            c0++;
        end
        check("timeout_set", 32'(bus.timeout), 1);
        check("timeout_delay", to_cyc - dv_cyc, LIMIT);
        check("timeout_data", 32'(bus.data), 0);
        send(8'h10, 1'b1);
        bus.rx = 1'b1;
        tick(BIT);
        drain(BIT);
        check("timeout_clear", 32'(bus.timeout), 0);
        check("timeout_new_data", 32'(bus.data), 8'h10);
`else
        tick(LIMIT + BIT);
        check("no_timeout", 32'(bus.timeout), 0);
        check("no_timeout_data", 32'(bus.data), 8'h42);
`endif
        tick(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
